// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads every data-memory word and streams it out LSB-first over a valid/ready byte channel
module mem_dump_reader #(
  parameter int NB_DATA_BUS    = 32,
  parameter int NB_DATA        = 8,
  parameter int N_ADDRESS      = 64,
  parameter int NB_ADDRESS     = $clog2(N_ADDRESS),
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic [NB_ADDRESS-1:0]  o_r_addr,
  output logic                   o_r_en,
  output logic                   o_r_signing,
  output logic [1:0]             o_r_addressing,
  input  logic [NB_DATA_BUS-1:0] i_r_data,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam int N_BYTES     = NB_DATA_BUS / NB_DATA;
  localparam int NB_BYTE_CNT = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam int NB_LAT      = $clog2(MEM_RD_LATENCY + 1);
  localparam logic [NB_ADDRESS-1:0]  LAST_ADDR = NB_ADDRESS'(N_ADDRESS - N_BYTES);
  localparam logic [NB_ADDRESS-1:0]  STEP      = NB_ADDRESS'(N_BYTES);
  localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(N_BYTES - 1);
  localparam logic [NB_LAT-1:0]      LAST_LAT  = NB_LAT'(MEM_RD_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  state_t                 state;
  logic [NB_ADDRESS-1:0]  addr;
  logic [NB_DATA_BUS-1:0] shreg;
  logic [NB_BYTE_CNT-1:0] byte_cnt;
  logic [NB_LAT-1:0]      lat_cnt;
  logic                   abort_pend;
  assign o_r_addr       = addr;
  assign o_r_signing    = 1'b0;
  assign o_r_addressing = 2'b11;
  // Outputs are registered: each transition sets the values the next state presents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      abort_pend <= 1'b0;
      o_r_en     <= 1'b0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_r_en <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state  <= READ;
          o_r_en <= 1'b1;
          o_busy <= 1'b1;
        end
        READ: if (i_abort) begin
          state  <= IDLE;
          addr   <= '0;
          o_busy <= 1'b0;
        end else begin
          state   <= WAIT;
          lat_cnt <= '0;
        end
        WAIT: if (i_abort) begin
          state  <= IDLE;
          addr   <= '0;
          o_busy <= 1'b0;
        end else if (lat_cnt == LAST_LAT) begin
          state      <= SEND;
          shreg      <= i_r_data;
          o_tx_data  <= i_r_data[NB_DATA-1:0];
          o_tx_valid <= 1'b1;
          byte_cnt   <= '0;
          abort_pend <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        SEND: if (i_tx_ready) begin
          shreg     <= shreg >> NB_DATA;
          o_tx_data <= shreg[2*NB_DATA-1:NB_DATA];
          byte_cnt  <= byte_cnt + 1'b1;
          if (i_abort || abort_pend) begin
            state      <= IDLE;
            addr       <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            abort_pend <= 1'b0;
          end else if (byte_cnt == LAST_BYTE) begin
            o_tx_valid <= 1'b0;
            if (addr == LAST_ADDR) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state  <= READ;
              addr   <= addr + STEP;
              o_r_en <= 1'b1;
            end
          end
        end else if (i_abort) begin
          abort_pend <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          addr   <= '0;
          o_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          addr       <= '0;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed checks of dump stream, memory port, start/abort/reset behaviour
module tb_mem_dump_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [5:0] r_addr;
  logic r_en, r_signing, tx_valid, busy, done;
  logic [1:0] r_addressing;
  logic [31:0] r_data;
  logic [7:0] tx_data;
  logic [31:0] mem [16];
  int checks = 0, failures = 0;
  logic [7:0] rx_q[$];
  int rd_addr_q[$];
  int done_cnt = 0, stab_err = 0, ren_err = 0, tie_err = 0, stall_cnt = 0;
  logic prev_stall = 1'b0, prev_ren = 1'b0;
  logic [7:0] prev_data = '0;
  int rb, ab, db;

  always #5 clk = ~clk;

  mem_dump_reader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_r_addr(r_addr), .o_r_en(r_en), .o_r_signing(r_signing), .o_r_addressing(r_addressing),
    .i_r_data(r_data), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done)
  );

  always @(posedge clk) if (r_en) r_data <= mem[r_addr[5:2]];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_ren = 1'b0;
    end else begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid && !tx_ready) stall_cnt++;
      if (r_en) rd_addr_q.push_back(int'(r_addr));
      if (done) done_cnt++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
      if (r_en && prev_ren) ren_err++;
      if (r_signing !== 1'b0 || r_addressing !== 2'b11 || (r_en && r_addr[1:0] !== 2'b00) || (tx_valid && !busy)) tie_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_ren = r_en;
    end
  end

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = mem[n / 4];
    return w[8 * (n % 4) +: 8];
  endfunction

  function automatic int bad_idx();
    if (rx_q.size() - rb != 64) return -2;
    for (int n = 0; n < 64; n++) if (rx_q[rb + n] !== exp_byte(n)) return n;
    return -1;
  endfunction

  task automatic mark();
    rb = rx_q.size();
    ab = rd_addr_q.size();
    db = done_cnt;
  endtask

  task automatic do_dump(input int stall_at, input int stall_len, input bit rnd, input bit hammer,
                         output int cycles, output bit timeout);
    mark();
    start = 1'b1;
    tx_ready = 1'b1;
    cycles = 0;
    @(posedge clk); #1;
    while (done_cnt == db && cycles < 3000) begin
      start = hammer;
      tx_ready = (cycles >= stall_at && cycles < stall_at + stall_len) ? 1'b0 :
                 rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    timeout = (done_cnt == db);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 16; i++) mem[i] = 32'h03020100 + 32'(i) * 32'h04040404;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || r_en !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: valid=%b busy=%b r_en=%b done=%b, required all 0", tx_valid, busy, r_en, done); end
    checks++; if (r_addr !== 6'd0 || tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_data: r_addr=%0d tx_data=%h, required 0 and 00", r_addr, tx_data); end
    checks++; if (r_signing !== 1'b0 || r_addressing !== 2'b11) begin
      failures++; $display("FAIL reset_ties: signing=%b addressing=%b, required 0 and 11", r_signing, r_addressing); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || r_en !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b valid=%b r_en=%b, required 0", busy, tx_valid, r_en); end
  endtask

  task automatic test_full_dump();
    int cyc, bad;
    bit to;
    load_basic();
    do_dump(1000, 0, 1'b0, 1'b0, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL full_timeout: no o_done within budget, cycles=%0d", cyc); end
    checks++; if (rx_q.size() - rb != 64) begin
      failures++; $display("FAIL full_count: got %0d bytes, required 64", rx_q.size() - rb); end
    if (rx_q.size() - rb >= 8) begin
      checks++; if (rx_q[rb] !== 8'h44 || rx_q[rb + 3] !== 8'h11 || rx_q[rb + 4] !== 8'hDD || rx_q[rb + 7] !== 8'hAA) begin
        failures++; $display("FAIL full_order: bytes 0,3,4,7 = %h %h %h %h, required 44 11 dd aa",
                             rx_q[rb], rx_q[rb + 3], rx_q[rb + 4], rx_q[rb + 7]); end
    end
    bad = bad_idx();
    checks++; if (bad != -1) begin failures++; $display("FAIL full_stream: first bad index %0d, required -1", bad); end
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL full_done: %0d pulses, required 1", done_cnt - db); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy: busy=%b after done, required 0", busy); end
    checks++; if (cyc > 16 * 7) begin failures++; $display("FAIL full_throughput: %0d cycles, required <= %0d", cyc, 16 * 7); end
    checks++; if (rd_addr_q.size() - ab != 16) begin
      failures++; $display("FAIL port_reads: %0d read pulses, required 16", rd_addr_q.size() - ab); end
    bad = -1;
    for (int i = 0; i < 16 && ab + i < rd_addr_q.size(); i++) if (bad < 0 && rd_addr_q[ab + i] != 4 * i) bad = i;
    checks++; if (bad != -1) begin
      failures++; $display("FAIL port_addr: read %0d at addr %0d, required %0d", bad, rd_addr_q[ab + bad], 4 * bad); end
    checks++; if (ren_err != 0 || tie_err != 0) begin
      failures++; $display("FAIL port_rules: ren_err=%0d tie_err=%0d, required 0 0", ren_err, tie_err); end
  endtask

  task automatic test_stall_random();
    int cyc, bad, sc;
    bit to;
    load_seq();
    sc = stall_cnt;
    do_dump(10, 10, 1'b1, 1'b0, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout: no o_done within budget, cycles=%0d", cyc); end
    bad = bad_idx();
    checks++; if (bad != -1) begin failures++; $display("FAIL stall_stream: first bad index %0d, required -1", bad); end
    checks++; if (stall_cnt - sc < 10) begin
      failures++; $display("FAIL stall_held: %0d stalled valid cycles, required >= 10", stall_cnt - sc); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL stall_stable: %0d violations, required 0", stab_err); end
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL stall_done: %0d pulses, required 1", done_cnt - db); end
  endtask

  task automatic test_back_to_back();
    int cyc, bad;
    bit to;
    load_seq();
    do_dump(1000, 0, 1'b0, 1'b1, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL b2b_timeout: no o_done within budget"); end
    checks++; if (rx_q.size() - rb != 64 || done_cnt - db != 1 || rd_addr_q.size() - ab != 16) begin
      failures++; $display("FAIL b2b_single: bytes=%0d done=%0d reads=%0d, required 64 1 16",
                           rx_q.size() - rb, done_cnt - db, rd_addr_q.size() - ab); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
    do_dump(1000, 0, 1'b0, 1'b0, cyc, to);
    checks++; if (to || rd_addr_q.size() == ab || rd_addr_q[ab] != 0) begin
      failures++; $display("FAIL b2b_restart: timeout=%b reads=%0d, required first read at addr 0", to, rd_addr_q.size() - ab); end
    bad = bad_idx();
    checks++; if (bad != -1) begin failures++; $display("FAIL b2b_stream: first bad index %0d, required -1", bad); end
  endtask

  task automatic test_abort();
    int cyc, bad;
    bit to;
    load_seq();
    mark();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || r_en !== 1'b0) begin
      failures++; $display("FAIL abort_read: busy=%b r_en=%b one cycle after abort, required 0 0", busy, r_en); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != rb || done_cnt != db) begin
      failures++; $display("FAIL abort_read_quiet: bytes=%0d done=%0d, required 0 0", rx_q.size() - rb, done_cnt - db); end
    mark();
    start = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (rx_q.size() - rb < 21 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    tx_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h15) begin
      failures++; $display("FAIL abort_pending: valid=%b busy=%b data=%h, required 1 1 15", tx_valid, busy, tx_data); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rx_q.size() - rb != 22 || rx_q[rx_q.size() - 1] !== 8'h15) begin
      failures++; $display("FAIL abort_last: bytes=%0d last=%h, required 22 and 15", rx_q.size() - rb, rx_q[rx_q.size() - 1]); end
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, tx_valid); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt != db || rx_q.size() - rb != 22 || rd_addr_q.size() - ab != 6) begin
      failures++; $display("FAIL abort_quiet: done=%0d bytes=%0d reads=%0d, required 0 22 6",
                           done_cnt - db, rx_q.size() - rb, rd_addr_q.size() - ab); end
    do_dump(1000, 0, 1'b0, 1'b0, cyc, to);
    checks++; if (to || rd_addr_q.size() == ab || rd_addr_q[ab] != 0) begin
      failures++; $display("FAIL abort_restart: timeout=%b, required first read at addr 0", to); end
    bad = bad_idx();
    checks++; if (bad != -1) begin failures++; $display("FAIL abort_stream: first bad index %0d, required -1", bad); end
  endtask

  task automatic test_reset_mid_send();
    int cyc, bad;
    bit to;
    load_basic();
    start = 1'b1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL rst_reach_send: valid=%b, required 1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || r_en !== 1'b0 || tx_data !== 8'h00) begin
      failures++; $display("FAIL rst_async: valid=%b busy=%b r_en=%b data=%h, required 0 0 0 00", tx_valid, busy, r_en, tx_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_dump(1000, 0, 1'b0, 1'b0, cyc, to);
    checks++; if (to || rx_q.size() == rb || rx_q[rb] !== 8'h44) begin
      failures++; $display("FAIL rst_restart: timeout=%b first byte=%h, required 44", to, rx_q.size() > rb ? rx_q[rb] : 8'hxx); end
    bad = bad_idx();
    checks++; if (bad != -1) begin failures++; $display("FAIL rst_stream: first bad index %0d, required -1", bad); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_full_dump();
    test_stall_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
